wiener_raster_axis_tx: RTL and testbench

Transmitter at the output end of the denoising pipeline. It accepts Wiener-filtered pixels in block order (BLOCK_SIZE×BLOCK_SIZE blocks, row-major inside each block, blocks left to right), buffers one stripe of BLOCK_SIZE frame lines, and replays it as a raster-order AXI4-Stream master. This mirrors the AXI-stream input that loads frames into memory, with identical framing on the output:
- `m_axis_tuser` marks the first pixel of a frame.
- `m_axis_tlast` marks the last pixel of every line.

---
 rtl/wiener_raster_axis_tx.sv | 153 +++++++++++++++
 tb/tb_wiener_raster_axis_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wiener_raster_axis_tx.sv
// Stripe re-ordering transmitter: collects one stripe of BLOCK_SIZE lines in block
// order and replays it as a raster-order AXI4-Stream with tuser/tlast framing.
module wiener_raster_axis_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 8,
  parameter int MAX_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           frame_width,
  input  logic [15:0]           frame_height,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_start_of_frame,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done
);

  localparam int DEPTH  = BLOCK_SIZE * MAX_WIDTH;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LOG_BS = $clog2(BLOCK_SIZE);
  localparam logic [15:0] BS_M1 = 16'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t state;
  logic [15:0] width_q, height_q;
  logic [15:0] col, row, blk;
  logic [15:0] x, y, stripe;
  logic        last_loaded;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          accept, restart, wr_en, last_fill, load, end_stripe;
  logic [15:0]   eff_col, eff_row, eff_blk, eff_width;
  logic [AW-1:0] wr_addr, rd_addr;

  assign in_ready = !rst && (state != DRAIN);
  assign accept   = in_valid && in_ready;
  assign restart  = accept && in_start_of_frame;
  assign wr_en    = accept && (restart || state == FILL);

  // A start-of-frame beat always behaves as pixel 0 of a fresh frame.
  always_comb begin
    eff_col   = col;
    eff_row   = row;
    eff_blk   = blk;
    eff_width = width_q;
    if (restart) begin
      eff_col   = '0;
      eff_row   = '0;
      eff_blk   = '0;
      eff_width = frame_width;
    end
  end

  assign last_fill = (eff_col == BS_M1) && (eff_row == BS_M1) &&
                     (eff_blk == (eff_width >> LOG_BS) - 16'd1);
  assign wr_addr = AW'(eff_row) * AW'(eff_width) + (AW'(eff_blk) << LOG_BS) + AW'(eff_col);
  assign rd_addr = AW'(y) * AW'(width_q) + AW'(x);

  assign load       = (state == DRAIN) && (!m_axis_tvalid || (m_axis_tready && !last_loaded));
  assign end_stripe = (state == DRAIN) && m_axis_tvalid && m_axis_tready && last_loaded;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      width_q       <= '0;
      height_q      <= '0;
      col           <= '0;
      row           <= '0;
      blk           <= '0;
      x             <= '0;
      y             <= '0;
      stripe        <= '0;
      last_loaded   <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (wr_en) begin
        if (restart) begin
          width_q  <= frame_width;
          height_q <= frame_height;
          stripe   <= '0;
        end
        if (last_fill) begin
          state       <= DRAIN;
          col         <= '0;
          row         <= '0;
          blk         <= '0;
          x           <= '0;
          y           <= '0;
          last_loaded <= 1'b0;
        end else begin
          state <= FILL;
          if (eff_col == BS_M1) begin
            col <= '0;
            if (eff_row == BS_M1) begin
              row <= '0;
              blk <= eff_blk + 16'd1;
            end else begin
              row <= eff_row + 16'd1;
              blk <= eff_blk;
            end
          end else begin
            col <= eff_col + 16'd1;
            row <= eff_row;
            blk <= eff_blk;
          end
        end
      end

      // Each load either primes the output register or replaces a beat that is transferring.
      if (load) begin
        m_axis_tdata  <= mem[rd_addr];
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (x == width_q - 16'd1);
        m_axis_tuser  <= (stripe == 16'd0) && (x == 16'd0) && (y == 16'd0);
        if (x == width_q - 16'd1) begin
          x <= '0;
          y <= y + 16'd1;
          if (y == BS_M1) last_loaded <= 1'b1;
        end else begin
          x <= x + 16'd1;
        end
      end else if (end_stripe) begin
        m_axis_tvalid <= 1'b0;
        if (stripe < (height_q >> LOG_BS) - 16'd1) begin
          stripe <= stripe + 16'd1;
          state  <= FILL;
        end else begin
          frame_done <= 1'b1;
          state      <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_wiener_raster_axis_tx.sv
// Bench for wiener_raster_axis_tx: table of frame scenarios checked against a
// block-to-raster reordering model, plus hand sequences for reset behaviour.
module tb_wiener_raster_axis_tx;

  localparam int BS    = 8;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frame_width, frame_height;
  logic [31:0] in_data;
  logic        in_valid, in_start_of_frame, in_ready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  wiener_raster_axis_tx #(.DATA_WIDTH(32), .BLOCK_SIZE(BS), .MAX_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .frame_width(frame_width), .frame_height(frame_height),
    .in_data(in_data), .in_valid(in_valid), .in_start_of_frame(in_start_of_frame),
    .in_ready(in_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int h;
    bit bp;
    int restart_at;
    bit idle_junk;
    int exp_beats;
    int exp_tlast;
    int exp_tuser;
  } vec_t;

  vec_t vecs[6];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Raster position -> index of that pixel in the block-order input stream.
  function automatic logic [31:0] model_pixel(input int seed, input int w, input int n);
    int px, py, k;
    px = n % w;
    py = n / w;
    k  = (py / BS) * BS * w + (px / BS) * BS * BS + (py % BS) * BS + (px % BS);
    return (32'(seed) << 16) | 32'(k);
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic sof);
    int tries = 0;
    @(negedge clk);
    in_valid          = 1'b1;
    in_data           = d;
    in_start_of_frame = sof;
    while (!in_ready && tries < LIMIT) begin
      @(negedge clk);
      tries++;
    end
    check_output("in_ready_wait", 32'(tries >= LIMIT), 32'd0);
    @(posedge clk);
  endtask

  task automatic apply_stimulus(input int w, input int h, input int seed, input int restart_at,
                                input bit idle_junk, input int max_beats);
    frame_width  = 16'(w);
    frame_height = 16'(h);
    if (idle_junk) send_beat(32'hBAD0_0000, 1'b0);
    for (int i = 0; i < restart_at; i++) send_beat(32'hDEAD_0000 | 32'(i), i == 0);
    for (int k = 0; k < w * h && k < max_beats; k++) send_beat((32'(seed) << 16) | 32'(k), k == 0);
    @(negedge clk);
    in_valid          = 1'b0;
    in_start_of_frame = 1'b0;
  endtask

  task automatic monitor_frame(input vec_t v, input int seed);
    int n = 0, cycles = 0, tl = 0, tu = 0;
    bit done = 0, pend_done = 0, pend_rdy = 0, prev_stall = 0;
    logic [31:0] pd;
    logic pl, pu;
    int total = v.w * v.h;
    while (!done && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
      if (pend_done) begin
        check_output("frame_done", 32'(frame_done), 32'd1);
        check_output("tvalid_drop", 32'(m_axis_tvalid), 32'd0);
        check_output("in_ready_idle", 32'(in_ready), 32'd1);
        done = 1;
      end else begin
        check_output("frame_done_early", 32'(frame_done), 32'd0);
        if (pend_rdy) begin
          check_output("in_ready_turnaround", 32'(in_ready), 32'd1);
          pend_rdy = 0;
        end
        if (prev_stall) begin
          check_output("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
          check_output("stall_tdata", m_axis_tdata, pd);
          check_output("stall_tlast", 32'(m_axis_tlast), 32'(pl));
          check_output("stall_tuser", 32'(m_axis_tuser), 32'(pu));
        end
        if (m_axis_tvalid) check_output("in_ready_drain", 32'(in_ready), 32'd0);
        m_axis_tready = v.bp ? ($urandom_range(0, 1) != 0) : 1'b1;
        if (m_axis_tvalid && m_axis_tready) begin
          check_output("tdata", m_axis_tdata, model_pixel(seed, v.w, n));
          check_output("tlast", 32'(m_axis_tlast), 32'((n % v.w) == v.w - 1));
          check_output("tuser", 32'(m_axis_tuser), 32'(n == 0));
          tl += int'(m_axis_tlast);
          tu += int'(m_axis_tuser);
          n++;
          if (n == total) pend_done = 1;
          else if (n % (BS * v.w) == 0) pend_rdy = 1;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        pd = m_axis_tdata;
        pl = m_axis_tlast;
        pu = m_axis_tuser;
      end
    end
    check_output("frame_timeout", 32'(done), 32'd1);
    check_output("beat_count", 32'(n), 32'(v.exp_beats));
    check_output("tlast_count", 32'(tl), 32'(v.exp_tlast));
    check_output("tuser_count", 32'(tu), 32'(v.exp_tuser));
    m_axis_tready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int seed);
    fork
      apply_stimulus(v.w, v.h, seed, v.restart_at, v.idle_junk, v.w * v.h);
      monitor_frame(v, seed);
    join
  endtask

  initial begin
    int n, cycles;
    vecs[0] = '{w:16, h:16, bp:0, restart_at:-1, idle_junk:1, exp_beats:256, exp_tlast:16, exp_tuser:1};
    vecs[1] = '{w:16, h:16, bp:1, restart_at:-1, idle_junk:0, exp_beats:256, exp_tlast:16, exp_tuser:1};
    vecs[2] = '{w:16, h:16, bp:0, restart_at:40, idle_junk:0, exp_beats:256, exp_tlast:16, exp_tuser:1};
    vecs[3] = '{w:64, h:8,  bp:0, restart_at:-1, idle_junk:0, exp_beats:512, exp_tlast:8,  exp_tuser:1};
    vecs[4] = '{w:8,  h:8,  bp:1, restart_at:-1, idle_junk:1, exp_beats:64,  exp_tlast:8,  exp_tuser:1};
    vecs[5] = '{w:32, h:16, bp:1, restart_at:-1, idle_junk:0, exp_beats:512, exp_tlast:16, exp_tuser:1};

    rst               = 1'b1;
    in_valid          = 1'b0;
    in_start_of_frame = 1'b0;
    in_data           = '0;
    frame_width       = 16'd16;
    frame_height      = 16'd16;
    m_axis_tready     = 1'b0;

    repeat (3) @(negedge clk);
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_output("rst_tdata", m_axis_tdata, 32'd0);
    check_output("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i + 1);

    // Reset in the middle of draining the first stripe.
    apply_stimulus(16, 16, 9, -1, 0, 128);
    m_axis_tready = 1'b1;
    n = 0;
    cycles = 0;
    while (n < 70 && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
      if (m_axis_tvalid) begin
        check_output("pre_rst_tdata", m_axis_tdata, model_pixel(9, 16, n));
        n++;
      end
    end
    check_output("pre_rst_timeout", 32'(n), 32'd70);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_output("mid_rst_tdata", m_axis_tdata, 32'd0);
    check_output("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_output("mid_rst_tuser", 32'(m_axis_tuser), 32'd0);
    check_output("mid_rst_frame_done", 32'(frame_done), 32'd0);
    check_output("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    m_axis_tready = 1'b0;
    @(negedge clk);
    check_output("mid_rst_release", 32'(in_ready), 32'd1);
    run_vec(vecs[0], 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
